// File: rtl/reduce_pkg.sv
// Shared definitions for the reduction stream blocks (transmitter and reduce_sum).
package reduce_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_RES = 2'd2
  } state_e;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_BUFFER_DEPTH = 256;
  localparam int DEF_ADDR_W       = 8;

endpackage

// File: rtl/reduce_stream_if.sv
// Data/valid/ready stream carrying frame words toward the reduction block.
interface reduce_stream_if #(
    parameter int DATA_W = 32
) ();

    // A word transfers on any cycle where valid & ready; once valid is raised, the
    // master holds data and valid steady until that transfer, and ready may toggle freely.
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/reduce_frame_buf.sv
// Frame storage: one write port, one registered read port with a read enable.
module reduce_frame_buf #(
    parameter int DATA_W       = 32,
    parameter int BUFFER_DEPTH = 256,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [BUFFER_DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    // The read register doubles as the stream output register, so it holds while disabled.
    always_ff @(posedge clk) begin
        if (rst)          rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/reduce_stream_tx.sv
// Frame transmitter: streams a host-loaded frame, then waits for the downstream result.
module reduce_stream_tx
    import reduce_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
    parameter int ADDR_W       = $clog2(BUFFER_DEPTH),
    parameter int TIMEOUT      = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    reduce_stream_if.master   out,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_valid,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              timeout,
    output state_e            dbg_state
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              busy_q;
    logic              out_valid_q;
    logic              done_q;
    logic              timeout_q;
    logic [DATA_W-1:0] result_q;

    logic              hs;
    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic [DATA_W-1:0] rd_data;

    assign hs = out_valid_q & out.ready;

    // Word 0 is fetched on the start cycle; later words are fetched on the handshake
    // of the word before, so the next word is ready the following cycle.
    always_comb begin
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        if (state_q == IDLE) begin
            rd_en_d = start;
        end else if (state_q == STREAM) begin
            rd_en_d   = hs && (idx_q != LAST_IDX);
            rd_addr_d = idx_q + ADDR_W'(1);
        end
    end

    reduce_frame_buf #(
        .DATA_W       (DATA_W),
        .BUFFER_DEPTH (BUFFER_DEPTH),
        .ADDR_W       (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en && (state_q == IDLE)),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en_d),
        .rd_addr_i (rd_addr_d),
        .rd_data_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wait_cnt_q  <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            result_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= STREAM;
                        busy_q      <= 1'b1;
                        timeout_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        idx_q       <= '0;
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (idx_q == LAST_IDX) begin
                            state_q     <= WAIT_RES;
                            out_valid_q <= 1'b0;
                            idx_q       <= '0;
                            wait_cnt_q  <= '0;
                        end else begin
                            idx_q <= idx_q + ADDR_W'(1);
                        end
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        result_q <= res_data;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out.valid = out_valid_q;
    assign out.data  = rd_data;
    assign result    = result_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_reduce_stream_tx.sv
// Directed bench for reduce_stream_tx with a 4-word frame and an 8-cycle result timeout.
module tb_reduce_stream_tx;
  import reduce_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int TMO   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic [DW-1:0] res_data;
  logic          res_valid;
  logic [DW-1:0] result;
  logic          done;
  logic          timeout;
  state_e        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] frame_w[DEPTH];
  logic [DW-1:0] exp_q[$];

  reduce_stream_if #(.DATA_W(DW)) s_if ();

  reduce_stream_tx #(
    .DATA_W       (DW),
    .BUFFER_DEPTH (DEPTH),
    .ADDR_W       (AW),
    .TIMEOUT      (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .busy      (busy),
    .out       (s_if),
    .res_data  (res_data),
    .res_valid (res_valid),
    .result    (result),
    .done      (done),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // driver tasks: inputs are set and outputs observed at the falling edge
  task automatic load_frame();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_addr = i[AW-1:0];
      wr_data = frame_w[i];
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_if.valid !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b valid=%b done=%b timeout=%b expected all 0",
               busy, s_if.valid, done, timeout);
    end
    checks++;
    if (s_if.data !== '0 || result !== '0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_data: data=%0d result=%0d state=%0d expected 0 0 IDLE",
               s_if.data, result, dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (s_if.valid !== 1'b1 || s_if.data !== frame_w[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL stream_word%0d: valid=%b data=%0d busy=%b expected valid=1 data=%0d busy=1",
                 i, s_if.valid, s_if.data, busy, frame_w[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (s_if.valid !== 1'b0 || dbg_state !== WAIT_RES) begin
      errors++;
      $display("FAIL stream_end: valid=%b state=%0d expected valid=0 state=WAIT_RES",
               s_if.valid, dbg_state);
    end
    res_valid = 1'b1;
    res_data  = 32'd10;
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'd10 || timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_done: done=%b result=%0d timeout=%b busy=%b expected 1 10 0 0",
               done, result, timeout, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL stream_done_pulse: done=%b expected 0", done);
    end
  endtask

  task automatic test_backpressure();
    int hs_n;
    exp_q = {};
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(frame_w[i]);
    hs_n  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40 && hs_n < DEPTH; c++) begin
      s_if.ready = ((c % 4) == 0) || ((c % 4) == 3);
      checks++;
      if (s_if.valid !== 1'b1 || s_if.data !== exp_q[0]) begin
        errors++;
        $display("FAIL bp_cycle%0d: valid=%b data=%0d expected valid=1 data=%0d",
                 c, s_if.valid, s_if.data, exp_q[0]);
      end
      if (s_if.valid === 1'b1 && s_if.ready === 1'b1) begin
        void'(exp_q.pop_front());
        hs_n++;
      end
      @(negedge clk);
    end
    s_if.ready = 1'b1;
    checks++;
    if (hs_n != DEPTH || s_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: handshakes=%0d valid=%b expected %0d and valid=0",
               hs_n, s_if.valid, DEPTH);
    end
    res_valid = 1'b1;
    res_data  = 32'd33;
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'd33 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: done=%b result=%0d timeout=%b expected 1 33 0",
               done, result, timeout);
    end
    @(negedge clk);
  endtask

  task automatic test_sticky_result();
    logic [DW-1:0] exp_res[2];
    exp_res   = '{32'd15, 32'd20};
    res_valid = 1'b1;
    res_data  = exp_res[0];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (s_if.valid !== 1'b1 || s_if.data !== frame_w[i] || done !== 1'b0) begin
          errors++;
          $display("FAIL sticky_f%0d_word%0d: valid=%b data=%0d done=%b expected 1 %0d 0",
                   f, i, s_if.valid, s_if.data, done, frame_w[i]);
        end
        @(negedge clk);
      end
      checks++;
      if (s_if.valid !== 1'b0 || done !== 1'b0 || dbg_state !== WAIT_RES) begin
        errors++;
        $display("FAIL sticky_f%0d_entry: valid=%b done=%b state=%0d expected 0 0 WAIT_RES",
                 f, s_if.valid, done, dbg_state);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || result !== exp_res[f] || timeout !== 1'b0) begin
        errors++;
        $display("FAIL sticky_f%0d_done: done=%b result=%0d timeout=%b expected 1 %0d 0",
                 f, done, result, timeout, exp_res[f]);
      end
      if (f == 0) begin
        // back-to-back: restart in the same cycle done is reported
        res_data = exp_res[1];
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    res_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (s_if.valid !== 1'b1 || s_if.data !== frame_w[i]) begin
        errors++;
        $display("FAIL tmo_word%0d: valid=%b data=%0d expected 1 %0d",
                 i, s_if.valid, s_if.data, frame_w[i]);
      end
      @(negedge clk);
    end
    for (int c = 0; c < TMO; c++) begin
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || dbg_state !== WAIT_RES) begin
        errors++;
        $display("FAIL tmo_wait%0d: done=%b busy=%b state=%0d expected 0 1 WAIT_RES",
                 c, done, busy, dbg_state);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || timeout !== 1'b1 || result !== 32'd20 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_done: done=%b timeout=%b result=%0d busy=%b expected 1 1 20 0",
               done, timeout, result, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_hold: done=%b timeout=%b expected done=0 timeout=1", done, timeout);
    end
  endtask

  task automatic test_locked();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL lock_tmo_clear: timeout=%b expected 0", timeout);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (s_if.valid !== 1'b1 || s_if.data !== frame_w[i]) begin
        errors++;
        $display("FAIL lock_word%0d: valid=%b data=%0d expected 1 %0d",
                 i, s_if.valid, s_if.data, frame_w[i]);
      end
      start   = (i == 1);
      wr_en   = (i == 1);
      wr_addr = '0;
      wr_data = 32'd99;
      @(negedge clk);
    end
    start     = 1'b0;
    wr_en     = 1'b0;
    res_valid = 1'b1;
    res_data  = 32'd44;
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'd44) begin
      errors++;
      $display("FAIL lock_done: done=%b result=%0d expected 1 44", done, result);
    end
    @(negedge clk);
    checks++;
    if (s_if.valid !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL lock_no_queue: valid=%b busy=%b state=%0d expected 0 0 IDLE",
               s_if.valid, busy, dbg_state);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (s_if.valid !== 1'b1 || s_if.data !== frame_w[i]) begin
        errors++;
        $display("FAIL lock_next_word%0d: valid=%b data=%0d expected 1 %0d",
                 i, s_if.valid, s_if.data, frame_w[i]);
      end
      @(negedge clk);
    end
    res_valid = 1'b1;
    res_data  = 32'd45;
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'd45) begin
      errors++;
      $display("FAIL lock_next_done: done=%b result=%0d expected 1 45", done, result);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bit seen_done;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (s_if.valid !== 1'b1 || s_if.data !== frame_w[i]) begin
        errors++;
        $display("FAIL mrst_word%0d: valid=%b data=%0d expected 1 %0d",
                 i, s_if.valid, s_if.data, frame_w[i]);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (s_if.valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || result !== '0 ||
        dbg_state !== IDLE) begin
      errors++;
      $display("FAIL mrst_state: valid=%b busy=%b done=%b result=%0d state=%0d expected 0 0 0 0 IDLE",
               s_if.valid, busy, done, result, dbg_state);
    end
    seen_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (done === 1'b1 || s_if.valid === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL mrst_quiet: saw done or valid after reset, expected none");
    end
    exp_q = {};
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(frame_w[i]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (s_if.valid !== 1'b1 || s_if.data !== exp_q[0]) begin
        errors++;
        $display("FAIL mrst_restart_word%0d: valid=%b data=%0d expected 1 %0d",
                 i, s_if.valid, s_if.data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    res_valid = 1'b1;
    res_data  = 32'd55;
    @(negedge clk);
    res_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'd55 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL mrst_done: done=%b result=%0d timeout=%b expected 1 55 0",
               done, result, timeout);
    end
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    start      = 1'b0;
    res_data   = '0;
    res_valid  = 1'b0;
    s_if.ready = 1'b1;
    frame_w    = '{32'd1, 32'd2, 32'd3, 32'd4};

    test_reset();
    load_frame();
    test_stream();
    test_backpressure();
    test_sticky_result();
    test_timeout();
    test_locked();
    test_mid_reset();

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
